// File: rtl/mips_lite_pipelined.sv
// 5-stage pipelined MIPS-Lite CPU (IF/ID/EX/MEM/WB) with forwarding,
// load-use stall, EX-resolved control flow and single-cycle DIVU.

// Byte-addressed little-endian word memory; contents are not reset
module mem_bytes #(
  parameter int BYTES = 128,
  parameter int AW    = $clog2(BYTES)
) (
  input  logic          i_clk,
  input  logic [AW-1:2] i_addr,
  input  logic          i_we,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [7:0]    mem_array [0:BYTES-1];
  logic [AW-1:0] w_b0, w_b1, w_b2, w_b3;

  // Address is word-aligned by construction and wraps at the array size
  assign w_b0 = {i_addr, 2'd0};
  assign w_b1 = {i_addr, 2'd1};
  assign w_b2 = {i_addr, 2'd2};
  assign w_b3 = {i_addr, 2'd3};
  assign o_rdata = {mem_array[w_b3], mem_array[w_b2], mem_array[w_b1], mem_array[w_b0]};

  // Full-word write, low byte at the lowest address
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_array[w_b0] <= i_wdata[7:0];
      mem_array[w_b1] <= i_wdata[15:8];
      mem_array[w_b2] <= i_wdata[23:16];
      mem_array[w_b3] <= i_wdata[31:24];
    end
  end
endmodule

// 32 x 32 register file, $0 hardwired, write-through to same-cycle reads
module reg_file (
  input  logic        i_clk,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] file_array [0:31];

  // Reads: $0 is zero, otherwise a WB write to the same register wins
  always_comb begin
    o_rd1 = file_array[i_ra1];
    o_rd2 = file_array[i_ra2];
    if (i_ra1 == 5'd0)                    o_rd1 = '0;
    else if (i_we && (i_wa == i_ra1))     o_rd1 = i_wd;
    if (i_ra2 == 5'd0)                    o_rd2 = '0;
    else if (i_we && (i_wa == i_ra2))     o_rd2 = i_wd;
  end

  // Writes to $0 are dropped; file is not reset
  always_ff @(posedge i_clk) begin
    if (i_we && (i_wa != 5'd0)) file_array[i_wa] <= i_wd;
  end
endmodule

module mips_lite_pipelined #(
  parameter int IMEM_BYTES = 128,
  parameter int DMEM_BYTES = 128
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = $clog2(IMEM_BYTES);
  localparam int DAW = $clog2(DMEM_BYTES);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SRL, ALU_HI, ALU_LO
  } alu_op_e;

  typedef struct packed {
    logic    reg_we;
    logic    mem_rd;
    logic    mem_wr;
    logic    use_imm;
    logic    beq;
    logic    jmp;
    logic    jr;
    logic    divu;
    alu_op_e alu_op;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    logic [25:0] jidx;
    logic [31:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc4;
  } idex_t;

  typedef struct packed {
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] st_data;
  } exmem_t;

  typedef struct packed {
    logic        reg_we;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } memwb_t;

  logic [31:0] pc;
  logic [5:0]  opcode, funct;
  logic [31:0] r_ifid_instr, r_ifid_pc4;
  idex_t       r_idex, w_idex_d;
  exmem_t      r_exmem;
  memwb_t      r_memwb;
  logic [31:0] r_hi, r_lo;

  logic [31:0] w_if_instr, w_dmem_rdata, w_rf_rd1, w_rf_rd2;
  logic [4:0]  w_id_rs, w_id_rt, w_id_rd;
  logic        w_stall, w_taken;
  logic [31:0] w_ex_a, w_ex_b, w_opb, w_alu, w_target, w_quot, w_rem;

  mem_bytes #(.BYTES(IMEM_BYTES)) InstrMem (
    .i_clk(clk), .i_addr(pc[IAW-1:2]), .i_we(1'b0), .i_wdata(32'd0), .o_rdata(w_if_instr)
  );

  mem_bytes #(.BYTES(DMEM_BYTES)) DatMem (
    .i_clk(clk), .i_addr(r_exmem.result[DAW-1:2]), .i_we(r_exmem.mem_wr),
    .i_wdata(r_exmem.st_data), .o_rdata(w_dmem_rdata)
  );

  reg_file RegFile (
    .i_clk(clk), .i_ra1(w_id_rs), .i_ra2(w_id_rt), .i_we(r_memwb.reg_we),
    .i_wa(r_memwb.dest), .i_wd(r_memwb.wdata), .o_rd1(w_rf_rd1), .o_rd2(w_rf_rd2)
  );

  assign opcode  = r_ifid_instr[31:26];
  assign funct   = r_ifid_instr[5:0];
  assign w_id_rs = r_ifid_instr[25:21];
  assign w_id_rt = r_ifid_instr[20:16];
  assign w_id_rd = r_ifid_instr[15:11];

  // Load-use: the LW in EX produces data one cycle too late for the ID instr
  assign w_stall = r_idex.ctl.mem_rd && ((r_idex.rt == w_id_rs) || (r_idex.rt == w_id_rt));

  // ID decode; unknown encodings leave control all-zero and act as NOP
  always_comb begin
    w_idex_d        = '0;
    w_idex_d.rs     = w_id_rs;
    w_idex_d.rt     = w_id_rt;
    w_idex_d.shamt  = r_ifid_instr[10:6];
    w_idex_d.jidx   = r_ifid_instr[25:0];
    w_idex_d.imm    = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
    w_idex_d.rs_val = w_rf_rd1;
    w_idex_d.rt_val = w_rf_rd2;
    w_idex_d.pc4    = r_ifid_pc4;
    case (opcode)
      6'd0: begin
        w_idex_d.dest = w_id_rd;
        case (funct)
          6'd32: begin w_idex_d.ctl.reg_we = 1'b1; w_idex_d.ctl.alu_op = ALU_ADD; end
          6'd34: begin w_idex_d.ctl.reg_we = 1'b1; w_idex_d.ctl.alu_op = ALU_SUB; end
          6'd36: begin w_idex_d.ctl.reg_we = 1'b1; w_idex_d.ctl.alu_op = ALU_AND; end
          6'd37: begin w_idex_d.ctl.reg_we = 1'b1; w_idex_d.ctl.alu_op = ALU_OR;  end
          6'd42: begin w_idex_d.ctl.reg_we = 1'b1; w_idex_d.ctl.alu_op = ALU_SLT; end
          6'd2:  begin w_idex_d.ctl.reg_we = 1'b1; w_idex_d.ctl.alu_op = ALU_SRL; end
          6'd16: begin w_idex_d.ctl.reg_we = 1'b1; w_idex_d.ctl.alu_op = ALU_HI;  end
          6'd18: begin w_idex_d.ctl.reg_we = 1'b1; w_idex_d.ctl.alu_op = ALU_LO;  end
          6'd8:  w_idex_d.ctl.jr   = 1'b1;
          6'd27: w_idex_d.ctl.divu = 1'b1;
          default: ;
        endcase
      end
      6'd35: begin
        w_idex_d.ctl.reg_we  = 1'b1;
        w_idex_d.ctl.mem_rd  = 1'b1;
        w_idex_d.ctl.use_imm = 1'b1;
        w_idex_d.dest        = w_id_rt;
      end
      6'd43: begin
        w_idex_d.ctl.mem_wr  = 1'b1;
        w_idex_d.ctl.use_imm = 1'b1;
      end
      6'd4:  w_idex_d.ctl.beq = 1'b1;
      6'd2:  w_idex_d.ctl.jmp = 1'b1;
      6'd13: begin
        w_idex_d.ctl.reg_we  = 1'b1;
        w_idex_d.ctl.use_imm = 1'b1;
        w_idex_d.ctl.alu_op  = ALU_OR;
        w_idex_d.dest        = w_id_rt;
        w_idex_d.imm         = {16'd0, r_ifid_instr[15:0]};
      end
      default: ;
    endcase
  end

  // EX operand forwarding: newest producer (EX/MEM) first, never for $0
  always_comb begin
    w_ex_a = r_idex.rs_val;
    w_ex_b = r_idex.rt_val;
    if (r_exmem.reg_we && (r_exmem.dest != 5'd0) && (r_exmem.dest == r_idex.rs))
      w_ex_a = r_exmem.result;
    else if (r_memwb.reg_we && (r_memwb.dest != 5'd0) && (r_memwb.dest == r_idex.rs))
      w_ex_a = r_memwb.wdata;
    if (r_exmem.reg_we && (r_exmem.dest != 5'd0) && (r_exmem.dest == r_idex.rt))
      w_ex_b = r_exmem.result;
    else if (r_memwb.reg_we && (r_memwb.dest != 5'd0) && (r_memwb.dest == r_idex.rt))
      w_ex_b = r_memwb.wdata;
  end

  assign w_opb = r_idex.ctl.use_imm ? r_idex.imm : w_ex_b;

  // ALU; SRL shifts rt, MFHI/MFLO read the HI/LO registers directly
  always_comb begin
    w_alu = '0;
    case (r_idex.ctl.alu_op)
      ALU_ADD: w_alu = w_ex_a + w_opb;
      ALU_SUB: w_alu = w_ex_a - w_opb;
      ALU_AND: w_alu = w_ex_a & w_opb;
      ALU_OR:  w_alu = w_ex_a | w_opb;
      ALU_SLT: w_alu = {31'd0, $signed(w_ex_a) < $signed(w_opb)};
      ALU_SRL: w_alu = w_ex_b >> r_idex.shamt;
      ALU_HI:  w_alu = r_hi;
      ALU_LO:  w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // Unsigned divide; divide by zero yields all-ones quotient, remainder = dividend
  always_comb begin
    w_quot = 32'hFFFF_FFFF;
    w_rem  = w_ex_a;
    if (w_ex_b != 32'd0) begin
      w_quot = w_ex_a / w_ex_b;
      w_rem  = w_ex_a % w_ex_b;
    end
  end

  // Control flow resolves in EX
  assign w_taken = (r_idex.ctl.beq && (w_ex_a == w_ex_b)) || r_idex.ctl.jmp || r_idex.ctl.jr;

  // Branch target selection for the taken path
  always_comb begin
    w_target = r_idex.pc4 + {r_idex.imm[29:0], 2'b00};
    if (r_idex.ctl.jr)       w_target = w_ex_a;
    else if (r_idex.ctl.jmp) w_target = {r_idex.pc4[31:28], r_idex.jidx, 2'b00};
  end

  // PC and IF/ID: a taken branch overrides a coincident load-use stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc           <= '0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (w_taken) begin
      pc           <= w_target;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (!w_stall) begin
      pc           <= pc + 32'd4;
      r_ifid_instr <= w_if_instr;
      r_ifid_pc4   <= pc + 32'd4;
    end
  end

  // ID/EX: bubble on stall, flush on taken branch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_idex <= '0;
    else if (w_taken || w_stall) r_idex <= '0;
    else                        r_idex <= w_idex_d;
  end

  // EX/MEM plus HI/LO update at the end of EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exmem <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_exmem.reg_we  <= r_idex.ctl.reg_we;
      r_exmem.mem_rd  <= r_idex.ctl.mem_rd;
      r_exmem.mem_wr  <= r_idex.ctl.mem_wr;
      r_exmem.dest    <= r_idex.dest;
      r_exmem.result  <= w_alu;
      r_exmem.st_data <= w_ex_b;
      if (r_idex.ctl.divu) begin
        r_hi <= w_rem;
        r_lo <= w_quot;
      end
    end
  end

  // MEM/WB: select load data or ALU result for write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memwb <= '0;
    end else begin
      r_memwb.reg_we <= r_exmem.reg_we;
      r_memwb.dest   <= r_exmem.dest;
      r_memwb.wdata  <= r_exmem.mem_rd ? w_dmem_rdata : r_exmem.result;
    end
  end
endmodule

// File: tb/tb_mips_lite_pipelined.sv
// Directed program bench for mips_lite_pipelined.
module tb_mips_lite_pipelined;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mips_lite_pipelined #(.IMEM_BYTES(128), .DMEM_BYTES(128)) dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    logic [31:0] w;
    w = {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int idx);
    logic [31:0] w;
    w = {op[5:0], idx[25:0]};
    return w;
  endfunction

  task automatic put_word(input int addr, input logic [31:0] w);
    logic [6:0] a;
    a = addr[6:0];
    dut.InstrMem.mem_array[a]        = w[7:0];
    dut.InstrMem.mem_array[a + 7'd1] = w[15:8];
    dut.InstrMem.mem_array[a + 7'd2] = w[23:16];
    dut.InstrMem.mem_array[a + 7'd3] = w[31:24];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [0:30];

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 128; i++) begin
      dut.InstrMem.mem_array[i] = 8'h00;
      dut.DatMem.mem_array[i]   = 8'h00;
    end
    for (int i = 0; i < 32; i++) dut.RegFile.file_array[i] = 32'd0;
    dut.RegFile.file_array[1] = 32'd5;
    dut.RegFile.file_array[2] = 32'd3;
    dut.DatMem.mem_array[0] = 8'h78;
    dut.DatMem.mem_array[1] = 8'h56;
    dut.DatMem.mem_array[2] = 8'h34;
    dut.DatMem.mem_array[3] = 8'h12;
    for (int i = 8; i < 12; i++) dut.DatMem.mem_array[i] = 8'hAA;

    prog[0]  = enc_r(1, 2, 3, 0, 32);        // ADD  $3,$1,$2
    prog[1]  = enc_r(1, 2, 4, 0, 34);        // SUB  $4,$1,$2
    prog[2]  = enc_i(35, 0, 5, 0);           // LW   $5,0($0)
    prog[3]  = enc_r(5, 5, 6, 0, 32);        // ADD  $6,$5,$5
    prog[4]  = enc_i(4, 1, 2, 1);            // BEQ  $1,$2,+1 (not taken)
    prog[5]  = enc_i(13, 0, 7, 16'hBEEF);    // ORI  $7,$0,0xBEEF
    prog[6]  = enc_i(4, 1, 1, 2);            // BEQ  $1,$1,+2 -> 36
    prog[7]  = enc_i(13, 0, 11, 16'h1111);   // flushed
    prog[8]  = enc_i(13, 0, 12, 16'h2222);   // flushed
    prog[9]  = enc_i(43, 0, 7, 8);           // SW   $7,8($0)
    prog[10] = enc_j(2, 13);                 // J    52
    prog[11] = enc_i(13, 0, 13, 1);          // flushed
    prog[12] = enc_i(13, 0, 13, 2);          // flushed
    prog[13] = enc_i(13, 0, 14, 64);         // ORI  $14,$0,64
    prog[14] = enc_r(14, 0, 0, 0, 8);        // JR   $14 -> 64
    prog[15] = enc_i(13, 0, 15, 1);          // flushed
    prog[16] = enc_i(13, 0, 1, 17);          // ORI  $1,$0,17
    prog[17] = enc_i(13, 0, 2, 9);           // ORI  $2,$0,9
    prog[18] = enc_i(13, 0, 2, 5);           // ORI  $2,$0,5
    prog[19] = enc_r(1, 2, 0, 0, 27);        // DIVU $1,$2
    prog[20] = enc_r(0, 0, 8, 0, 16);        // MFHI $8
    prog[21] = enc_r(0, 0, 9, 0, 18);        // MFLO $9
    prog[22] = enc_r(0, 1, 10, 2, 2);        // SRL  $10,$1,2
    prog[23] = enc_r(1, 2, 0, 0, 32);        // ADD  $0,$1,$2
    prog[24] = enc_r(0, 1, 18, 0, 32);       // ADD  $18,$0,$1
    prog[25] = enc_r(1, 0, 0, 0, 27);        // DIVU $1,$0
    prog[26] = enc_r(0, 0, 19, 0, 16);       // MFHI $19
    prog[27] = enc_r(0, 0, 20, 0, 18);       // MFLO $20
    prog[28] = enc_r(20, 1, 21, 0, 42);      // SLT  $21,$20,$1
    prog[29] = enc_r(6, 7, 22, 0, 36);       // AND  $22,$6,$7
    prog[30] = enc_j(2, 30);                 // J    120 (self loop)
    for (int i = 0; i < 31; i++) put_word(4 * i, prog[i]);

    #12 rst = 1'b1;
    #1;
    check("reset_pc", dut.pc, 32'd0);
    tick(1); check("pc_c1", dut.pc, 32'd4);  check("funct_add", {26'd0, dut.funct}, 32'd32);
    tick(1); check("pc_c2", dut.pc, 32'd8);  check("funct_sub", {26'd0, dut.funct}, 32'd34);
    tick(1); check("pc_c3", dut.pc, 32'd12); check("opcode_lw", {26'd0, dut.opcode}, 32'd35);
    tick(1); check("pc_c4", dut.pc, 32'd16);
    tick(1); check("pc_stall_hold", dut.pc, 32'd16);
    tick(1); check("pc_after_stall", dut.pc, 32'd20);
    tick(4); check("pc_beq_target", dut.pc, 32'd36);
    tick(60);

    check("add_r3", dut.RegFile.file_array[3], 32'd8);
    check("sub_r4", dut.RegFile.file_array[4], 32'd2);
    check("lw_r5", dut.RegFile.file_array[5], 32'h12345678);
    check("loaduse_r6", dut.RegFile.file_array[6], 32'h2468ACF0);
    check("ori_r7", dut.RegFile.file_array[7], 32'h0000BEEF);
    check("flush_r11", dut.RegFile.file_array[11], 32'd0);
    check("flush_r12", dut.RegFile.file_array[12], 32'd0);
    check("flush_r13", dut.RegFile.file_array[13], 32'd0);
    check("flush_r15", dut.RegFile.file_array[15], 32'd0);
    check("j_r14", dut.RegFile.file_array[14], 32'd64);
    check("ori_r1", dut.RegFile.file_array[1], 32'd17);
    check("ori_r2", dut.RegFile.file_array[2], 32'd5);
    check("mfhi_r8", dut.RegFile.file_array[8], 32'd2);
    check("mflo_r9", dut.RegFile.file_array[9], 32'd3);
    check("srl_r10", dut.RegFile.file_array[10], 32'd4);
    check("zero_r0", dut.RegFile.file_array[0], 32'd0);
    check("no_fwd_r0", dut.RegFile.file_array[18], 32'd17);
    check("div0_hi_r19", dut.RegFile.file_array[19], 32'd17);
    check("div0_lo_r20", dut.RegFile.file_array[20], 32'hFFFFFFFF);
    check("slt_r21", dut.RegFile.file_array[21], 32'd1);
    check("and_r22", dut.RegFile.file_array[22], 32'h0000ACE0);
    check("sw_b8", {24'd0, dut.DatMem.mem_array[8]}, 32'hEF);
    check("sw_b9", {24'd0, dut.DatMem.mem_array[9]}, 32'hBE);
    check("sw_b10", {24'd0, dut.DatMem.mem_array[10]}, 32'h00);
    check("sw_b11", {24'd0, dut.DatMem.mem_array[11]}, 32'h00);

    // Mid-program asynchronous reset, then a program that reads HI/LO first
    #3 rst = 1'b0;
    #1 check("midreset_pc", dut.pc, 32'd0);
    put_word(0, enc_r(0, 0, 24, 0, 16));     // MFHI $24
    put_word(4, enc_r(0, 0, 25, 0, 18));     // MFLO $25
    put_word(8, enc_j(2, 2));                // J 8 (self loop)
    put_word(12, 32'd0);
    dut.RegFile.file_array[24] = 32'hDEAD;
    dut.RegFile.file_array[25] = 32'hDEAD;
    #2 rst = 1'b1;
    tick(20);
    check("hi_reset_r24", dut.RegFile.file_array[24], 32'd0);
    check("lo_reset_r25", dut.RegFile.file_array[25], 32'd0);
    check("rf_kept_r3", dut.RegFile.file_array[3], 32'd8);
    check("dmem_kept_b8", {24'd0, dut.DatMem.mem_array[8]}, 32'hEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
